// File: rtl/vga_pixel_timing.sv
// SVGA raster timing generator that pops one FWFT FIFO word per active pixel
// and drives registered RGB, syncs and display enable to the TMDS encoder.
module vga_pixel_timing #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        display_enable,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [0:0]  state;

  logic act, hs, vs, last_pix, in_run, pop, starve;

  // The top byte of each FIFO word is padding and deliberately ignored.
  logic unused_pad;
  assign unused_pad = &{1'b0, fifo_rd_data[31:24]};

  assign act      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs       = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs       = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign in_run   = (state == ST_RUN);
  assign pop      = in_run && act && !fifo_empty;
  assign starve   = in_run && act && fifo_empty;

  assign fifo_rd_en = pop;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge counter values, giving the uniform one-cycle latency.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Run/idle decisions are taken only on the last pixel so frames are never split.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (last_pix) begin
      state <= enable ? ST_RUN : ST_IDLE;
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      red            <= '0;
      green          <= '0;
      blue           <= '0;
      hsync          <= ~SYNC_POL;
      vsync          <= ~SYNC_POL;
      display_enable <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      red            <= pop ? fifo_rd_data[23:16] : 8'h00;
      green          <= pop ? fifo_rd_data[15:8]  : 8'h00;
      blue           <= pop ? fifo_rd_data[7:0]   : 8'h00;
      hsync          <= hs ? SYNC_POL : ~SYNC_POL;
      vsync          <= vs ? SYNC_POL : ~SYNC_POL;
      display_enable <= act;
      frame_start    <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
    end
  end

  // Starvation outranks a simultaneous clear so no underflow event is lost.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (starve) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Randomized scoreboard bench for vga_pixel_timing using a reduced raster so
// many whole frames fit in a short run; expectations come from a raster model.
module tb_vga_pixel_timing;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 5, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic SP = 1'b1;

  logic        pixclk = 1'b0;
  logic        reset, enable, fifo_empty, underflow_clr;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en, hsync, vsync, display_enable, frame_start, underflow;
  logic [7:0]  red, green, blue;

  vga_pixel_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(SP)
  ) dut (
    .pixclk(pixclk), .reset(reset), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .display_enable(display_enable), .frame_start(frame_start),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic        rd_en;
    logic [23:0] rgb;
    logic        hs, vs, de, fs, uf;
  } exp_t;

  localparam exp_t RESET_EXP = '{rd_en: 1'b0, rgb: 24'h0, hs: ~SP, vs: ~SP,
                                 de: 1'b0, fs: 1'b0, uf: 1'b0};

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0, fails = 0;
  int          dut_pops = 0, pops_mark = 0;

  // Raster model: position is the cycle count since reset, folded by frame size.
  int          m_n = 0;
  bit          m_run = 1'b0, m_uf = 1'b0;
  exp_t        m_regs = RESET_EXP;
  logic [31:0] cur_word;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t (model pos %0d)", name, got, want, $time, m_n);
    end
  endtask

  function automatic logic [31:0] new_word();
    return {8'h00, 24'($urandom)};
  endfunction

  task automatic step(input logic rst, input logic en, input logic emp, input logic clr);
    int   h, v;
    bit   act, pop;
    exp_t e, nxt;
    @(posedge pixclk);
    #1;
    reset = rst; enable = en; fifo_empty = emp; underflow_clr = clr;
    fifo_rd_data = cur_word;
    h   = m_n % HT;
    v   = m_n / HT;
    act = (h < HA) && (v < VA);
    pop = m_run && act && !emp;
    e = m_regs;
    e.rd_en = pop;
    q.push_back(e);
    if (rst) begin
      nxt = RESET_EXP;
      m_n = 0; m_run = 1'b0; m_uf = 1'b0;
    end else begin
      nxt.rd_en = 1'b0;
      nxt.rgb   = pop ? cur_word[23:0] : 24'h0;
      nxt.de    = act;
      nxt.hs    = (h >= HA + HFP && h < HA + HFP + HS) ? SP : ~SP;
      nxt.vs    = (v >= VA + VFP && v < VA + VFP + VS) ? SP : ~SP;
      nxt.fs    = (m_n == 0);
      if (m_run && act && emp) m_uf = 1'b1;
      else if (clr)            m_uf = 1'b0;
      nxt.uf = m_uf;
      if (m_n == FRAME - 1) m_run = en;
      m_n = (m_n + 1) % FRAME;
    end
    if (pop) cur_word = new_word();
    m_regs = nxt;
  endtask

  task automatic run_to(input int target, input logic en);
    for (int i = 0; i < 2 * FRAME && m_n != target; i++) step(1'b0, en, 1'b0, 1'b0);
  endtask

  // Called right after the last pixel of a frame has been issued.
  task automatic frame_pops(input string name, input int want);
    @(negedge pixclk);
    #1;
    check(name, dut_pops - pops_mark, want);
    pops_mark = dut_pops;
  endtask

  initial begin
    forever begin
      @(negedge pixclk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, mon_e.rd_en});
        if (fifo_rd_en === 1'b1) dut_pops++;
        check("rgb", {8'h00, red, green, blue}, {8'h00, mon_e.rgb});
        check("hsync", {31'b0, hsync}, {31'b0, mon_e.hs});
        check("vsync", {31'b0, vsync}, {31'b0, mon_e.vs});
        check("display_enable", {31'b0, display_enable}, {31'b0, mon_e.de});
        check("frame_start", {31'b0, frame_start}, {31'b0, mon_e.fs});
        check("underflow", {31'b0, underflow}, {31'b0, mon_e.uf});
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; fifo_empty = 1'b0; underflow_clr = 1'b0;
    fifo_rd_data = 32'h0;
    cur_word = new_word();

    // Reset, then idle frames: sync running, black, no pops regardless of FIFO.
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2 * FRAME) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Enable with a full FIFO: RUN starts at the next frame boundary.
    run_to(0, 1'b0);
    pops_mark = dut_pops;
    for (int f = 0; f < 3; f++) begin
      repeat (FRAME) step(1'b0, 1'b1, 1'b0, 1'b0);
      frame_pops("pops_per_frame", (f == 0) ? 0 : HA * VA);
    end

    // Random starvation and clears while running.
    repeat (3 * FRAME) step(1'b0, 1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));

    // Directed starvation burst mid-line, then clear and resume.
    run_to(2 * HT + 2, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
    // Simultaneous starvation and clear: the set must win.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Enable dropped mid-frame: this frame completes, the next one is idle.
    run_to(0, 1'b1);
    pops_mark = dut_pops;
    run_to((VA / 2) * HT, 1'b1);
    run_to(0, 1'b0);
    frame_pops("pops_after_disable", HA * VA);
    repeat (FRAME) step(1'b0, 1'b0, 1'b0, 1'b0);
    frame_pops("pops_idle_frame", 0);

    // Reset mid-line while running; the raster restarts idle at (0,0).
    run_to(0, 1'b1);
    run_to(HT + 3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2 * FRAME) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Fully random traffic, including rare resets.
    repeat (20 * FRAME)
      step(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));

    repeat (3) @(negedge pixclk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
